// File: rtl/bypass_table_counter_if.sv
// bypass_table_counter_if: port bundle between the counter and the
// 256 x 24 bypass table wrapper (master = counter, slave = table).
//   tbl_wr_*  : write strobe, address, data (counter -> table)
//   tbl_rd_*  : read strobe, address (counter -> table)
//   tbl_rd_data_in / tbl_rd_valid_in : 1-cycle read return (table -> counter)
interface bypass_table_counter_if;
  logic [7:0]  tbl_wr_addr_out;
  logic [23:0] tbl_wr_data_out;
  logic        tbl_wr_enable_out;
  logic [7:0]  tbl_rd_addr_out;
  logic        tbl_rd_enable_out;
  logic [23:0] tbl_rd_data_in;
  logic        tbl_rd_valid_in;

  modport master (
    output tbl_wr_addr_out,
    output tbl_wr_data_out,
    output tbl_wr_enable_out,
    output tbl_rd_addr_out,
    output tbl_rd_enable_out,
    input  tbl_rd_data_in,
    input  tbl_rd_valid_in
  );

  modport slave (
    input  tbl_wr_addr_out,
    input  tbl_wr_data_out,
    input  tbl_wr_enable_out,
    input  tbl_rd_addr_out,
    input  tbl_rd_enable_out,
    output tbl_rd_data_in,
    output tbl_rd_valid_in
  );
endinterface

// File: rtl/bypass_table_counter.sv
// bypass_table_counter: read-modify-write occurrence counter for the
// arithmetic encoder bypass table; zero-fills the table after reset/clear.
// Ports: clk, rst (sync, active high), clear_in, sym_* (input stream),
//   entry_* (pre-update count stream), tbl (table master bundle),
//   init_done_out (high in IDLE/UPDATE).
// Option: define BYPASS_TBL_SAT_EN to saturate counts at 24'hFFFFFF
//   instead of wrapping modulo 2^24.
module bypass_table_counter #(
  parameter logic [23:0] INC_STEP = 24'd1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear_in,
  input  logic [7:0]             sym_in,
  input  logic                   sym_valid_in,
  output logic                   sym_ready_out,
  output logic [23:0]            entry_out,
  output logic [7:0]             entry_sym_out,
  output logic                   entry_valid_out,
  input  logic                   entry_ready_in,
  bypass_table_counter_if.master tbl,
  output logic                   init_done_out
);

  localparam logic [1:0] ST_INIT   = 2'd0;
  localparam logic [1:0] ST_IDLE   = 2'd1;
  localparam logic [1:0] ST_UPDATE = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [7:0]  init_cnt_q, init_cnt_d;
  logic [7:0]  sym_q, sym_d;
  logic [23:0] entry_q, entry_d;
  logic [7:0]  entry_sym_q, entry_sym_d;
  logic        entry_valid_q, entry_valid_d;
  logic [23:0] new_cnt;
  logic        wr_en;
  logic        rd_en;
  logic        ready;

`ifdef BYPASS_TBL_SAT_EN
  logic [24:0] sum;
  always_comb begin
    sum     = {1'b0, tbl.tbl_rd_data_in} + {1'b0, INC_STEP};
    new_cnt = sum[24] ? 24'hFF_FFFF : sum[23:0];
  end
`else
  always_comb new_cnt = tbl.tbl_rd_data_in + INC_STEP;
`endif

  always_comb begin
    state_d       = state_q;
    init_cnt_d    = init_cnt_q;
    sym_d         = sym_q;
    entry_d       = entry_q;
    entry_sym_d   = entry_sym_q;
    entry_valid_d = entry_valid_q && !entry_ready_in;
    wr_en         = 1'b0;
    rd_en         = 1'b0;
    ready         = 1'b0;
    tbl.tbl_wr_addr_out = 8'd0;
    tbl.tbl_wr_data_out = 24'd0;
    tbl.tbl_rd_addr_out = 8'd0;
    unique case (state_q)
      ST_INIT: begin
        wr_en               = 1'b1;
        tbl.tbl_wr_addr_out = init_cnt_q;
        init_cnt_d          = init_cnt_q + 8'd1;
        if (init_cnt_q == 8'hFF) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        // Only take a symbol when the output slot will be free by UPDATE.
        ready = !clear_in && (!entry_valid_q || entry_ready_in);
        rd_en = sym_valid_in && ready;
        tbl.tbl_rd_addr_out = sym_in;
        if (clear_in) begin
          state_d    = ST_INIT;
          init_cnt_d = 8'd0;
        end else if (rd_en) begin
          sym_d   = sym_in;
          state_d = ST_UPDATE;
        end
      end
      ST_UPDATE: begin
        wr_en               = 1'b1;
        tbl.tbl_wr_addr_out = sym_q;
        tbl.tbl_wr_data_out = new_cnt;
        entry_d             = tbl.tbl_rd_data_in;
        entry_sym_d         = sym_q;
        entry_valid_d       = 1'b1;
        state_d             = ST_IDLE;
      end
      default: state_d = ST_INIT;
    endcase
  end

  // Strobes are masked while rst is high so a reset landing on UPDATE
  // never commits its write.
  assign tbl.tbl_wr_enable_out = wr_en && !rst;
  assign tbl.tbl_rd_enable_out = rd_en && !rst;
  assign sym_ready_out         = ready && !rst;

  assign entry_out       = entry_q;
  assign entry_sym_out   = entry_sym_q;
  assign entry_valid_out = entry_valid_q;
  assign init_done_out   = (state_q != ST_INIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_INIT;
      init_cnt_q    <= 8'd0;
      sym_q         <= 8'd0;
      entry_q       <= 24'd0;
      entry_sym_q   <= 8'd0;
      entry_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      init_cnt_q    <= init_cnt_d;
      sym_q         <= sym_d;
      entry_q       <= entry_d;
      entry_sym_q   <= entry_sym_d;
      entry_valid_q <= entry_valid_d;
    end
  end

endmodule

// File: tb/tb_bypass_table_counter.sv
// tb_bypass_table_counter: directed bench for bypass_table_counter.
// dut0 uses INC_STEP=1, dut1 uses INC_STEP=24'h800000; each has a table model.
module tb_bypass_table_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic seed;
  logic [1:0] clr, sv, er;
  logic [1:0] srdy, ev, wen, ren, rv, idone;
  logic [1:0][7:0]  sym, esym, waddr, raddr;
  logic [1:0][23:0] eo, wdata;

  int errs = 0;
  int checks = 0;

  logic [23:0] mem0 [256];
  logic [23:0] mem1 [256];

`ifdef BYPASS_TBL_SAT_EN
  localparam logic [23:0] W2 = 24'hFF_FFFF;
  localparam logic [23:0] W3 = 24'hFF_FFFF;
`else
  localparam logic [23:0] W2 = 24'h00_0000;
  localparam logic [23:0] W3 = 24'h80_0000;
`endif

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  bypass_table_counter_if t0 ();
  bypass_table_counter_if t1 ();

  bypass_table_counter dut0 (
    .clk(clk), .rst(rst), .clear_in(clr[0]),
    .sym_in(sym[0]), .sym_valid_in(sv[0]),
    .sym_ready_out(srdy[0]),
    .entry_out(eo[0]), .entry_sym_out(esym[0]),
    .entry_valid_out(ev[0]), .entry_ready_in(er[0]),
    .tbl(t0), .init_done_out(idone[0])
  );

  bypass_table_counter #(.INC_STEP(24'h80_0000)) dut1 (
    .clk(clk), .rst(rst), .clear_in(clr[1]),
    .sym_in(sym[1]), .sym_valid_in(sv[1]),
    .sym_ready_out(srdy[1]),
    .entry_out(eo[1]), .entry_sym_out(esym[1]),
    .entry_valid_out(ev[1]), .entry_ready_in(er[1]),
    .tbl(t1), .init_done_out(idone[1])
  );

  assign wen[0]   = t0.tbl_wr_enable_out;
  assign ren[0]   = t0.tbl_rd_enable_out;
  assign waddr[0] = t0.tbl_wr_addr_out;
  assign raddr[0] = t0.tbl_rd_addr_out;
  assign wdata[0] = t0.tbl_wr_data_out;
  assign rv[0]    = t0.tbl_rd_valid_in;
  assign wen[1]   = t1.tbl_wr_enable_out;
  assign ren[1]   = t1.tbl_rd_enable_out;
  assign waddr[1] = t1.tbl_wr_addr_out;
  assign raddr[1] = t1.tbl_rd_addr_out;
  assign wdata[1] = t1.tbl_wr_data_out;
  assign rv[1]    = t1.tbl_rd_valid_in;

  always @(posedge clk) begin
    if (seed) begin
      for (int i = 0; i < 256; i++) mem0[i] <= 24'h5A_5A5A;
      t0.tbl_rd_data_in  <= 24'd0;
      t0.tbl_rd_valid_in <= 1'b0;
    end else begin
      if (t0.tbl_wr_enable_out)
        mem0[t0.tbl_wr_addr_out] <= t0.tbl_wr_data_out;
      if (t0.tbl_rd_enable_out)
        t0.tbl_rd_data_in <= mem0[t0.tbl_rd_addr_out];
      t0.tbl_rd_valid_in <= t0.tbl_rd_enable_out;
    end
  end

  always @(posedge clk) begin
    if (seed) begin
      for (int i = 0; i < 256; i++) mem1[i] <= 24'h5A_5A5A;
      t1.tbl_rd_data_in  <= 24'd0;
      t1.tbl_rd_valid_in <= 1'b0;
    end else begin
      if (t1.tbl_wr_enable_out)
        mem1[t1.tbl_wr_addr_out] <= t1.tbl_wr_data_out;
      if (t1.tbl_rd_enable_out)
        t1.tbl_rd_data_in <= mem1[t1.tbl_rd_addr_out];
      t1.tbl_rd_valid_in <= t1.tbl_rd_enable_out;
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int d, input logic [7:0] s,
                      input logic [23:0] exp,
                      input logic [23:0] exp_wr);
    sv[d]  = 1'b1;
    sym[d] = s;
    #1;
    chk("hs_ready", srdy[d], 1'b1);
    chk("hs_rd_en", ren[d], 1'b1);
    chk("hs_rd_addr", raddr[d], s);
    chk("hs_no_wr", wen[d], 1'b0);
    nxt();
    sv[d] = 1'b0;
    #1;
    chk("upd_wr_en", wen[d], 1'b1);
    chk("upd_wr_addr", waddr[d], s);
    chk("upd_wr_data", wdata[d], exp_wr);
    chk("upd_no_rd", ren[d], 1'b0);
    chk("upd_not_ready", srdy[d], 1'b0);
    chk("upd_rd_valid", rv[d], 1'b1);
    chk("upd_out_empty", ev[d], 1'b0);
    nxt();
    chk("out_valid", ev[d], 1'b1);
    chk("out_entry", eo[d], exp);
    chk("out_sym", esym[d], s);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst  = 1'b1;
    seed = 1'b1;
    clr  = 2'b00;
    sv   = 2'b00;
    er   = 2'b11;
    sym  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", ev, 2'b00);
    chk("rst_entry0", eo[0], 24'd0);
    chk("rst_sym0", esym[0], 8'd0);
    chk("rst_done", idone, 2'b00);
    chk("rst_ready", srdy, 2'b00);
    chk("rst_no_wr", wen, 2'b00);

    rst  = 1'b0;
    seed = 1'b0;
    #1;
    for (int k = 0; k < 256; k++) begin
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (wen[d] !== 1'b1 || waddr[d] !== 8'(k) ||
            wdata[d] !== 24'd0 || ren[d] !== 1'b0 ||
            srdy[d] !== 1'b0 || idone[d] !== 1'b0) begin
          errs++;
          $error("FAIL init_sweep: got addr %0h want %0h",
                 waddr[d], k);
        end
      end
      nxt();
    end
    chk("init_done", idone, 2'b11);
    chk("init_wr_off", wen, 2'b00);
    chk("idle_ready", srdy, 2'b11);
    chk("init_mem0", mem0[0], 24'd0);
    chk("init_mem255", mem0[255], 24'd0);

    send(0, 8'h41, 24'd0, 24'd1);
    send(0, 8'h41, 24'd1, 24'd2);
    send(0, 8'h41, 24'd2, 24'd3);
    chk("rep_mem41", mem0[8'h41], 24'd3);

    nxt();
    er[0] = 1'b0;
    send(0, 8'h41, 24'd3, 24'd4);
    sv[0]  = 1'b1;
    sym[0] = 8'h21;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (srdy[0] !== 1'b0 || ren[0] !== 1'b0 ||
          ev[0] !== 1'b1 || eo[0] !== 24'd3 ||
          esym[0] !== 8'h41) begin
        errs++;
        $error("FAIL bp_hold: got entry %0h want 3", eo[0]);
      end
      nxt();
    end
    er[0] = 1'b1;
    send(0, 8'h21, 24'd0, 24'd1);

    send(1, 8'h07, 24'd0, 24'h80_0000);
    send(1, 8'h07, 24'h80_0000, W2);
    send(1, 8'h07, W2, W3);

    nxt();
    send(0, 8'h10, 24'd0, 24'd1);
    send(0, 8'h10, 24'd1, 24'd2);
    clr[0] = 1'b1;
    sv[0]  = 1'b1;
    sym[0] = 8'h10;
    #1;
    chk("clr_not_ready", srdy[0], 1'b0);
    chk("clr_no_rd", ren[0], 1'b0);
    nxt();
    clr[0] = 1'b0;
    sv[0]  = 1'b0;
    for (int k = 0; k < 256; k++) begin
      checks++;
      if (wen[0] !== 1'b1 || waddr[0] !== 8'(k) ||
          wdata[0] !== 24'd0 || ren[0] !== 1'b0 ||
          idone[0] !== 1'b0) begin
        errs++;
        $error("FAIL clr_sweep: got addr %0h want %0h",
               waddr[0], k);
      end
      nxt();
    end
    chk("clr_done", idone[0], 1'b1);
    chk("clr_mem10", mem0[8'h10], 24'd0);
    chk("clr_mem41", mem0[8'h41], 24'd0);
    send(0, 8'h10, 24'd0, 24'd1);

    nxt();
    sv[0]  = 1'b1;
    sym[0] = 8'h30;
    #1;
    chk("rupd_hs", srdy[0], 1'b1);
    nxt();
    rst   = 1'b1;
    sv[0] = 1'b0;
    #1;
    chk("rupd_no_wr", wen[0], 1'b0);
    chk("rupd_no_rd", ren[0], 1'b0);
    nxt();
    rst = 1'b0;
    #1;
    chk("rupd_mem30", mem0[8'h30], 24'd0);
    chk("rupd_valid", ev[0], 1'b0);
    chk("rupd_entry", eo[0], 24'd0);
    chk("rupd_init_wr", wen[0], 1'b1);
    chk("rupd_init_addr", waddr[0], 8'd0);
    chk("rupd_not_done", idone[0], 1'b0);
    repeat (256) nxt();
    chk("rupd_done", idone[0], 1'b1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
